// File: rtl/fu_dispatch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fu_dispatch_pkg / fu_dispatch_ctrl_if                        |
// | Description : Issued-instruction type and the issue/FU handshake bundle    |
// |               between the issue table, the dispatch slots and the FUs.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package fu_dispatch_pkg;

   localparam int NUM_FU = 4;

   typedef struct packed {
      logic [15:0] pc;
      logic [7:0]  opcode;
      logic [3:0]  tag;
   } issued_instruction_t;

endpackage

interface fu_dispatch_ctrl_if #(
   parameter int NUM_FU_P = fu_dispatch_pkg::NUM_FU
);

   fu_dispatch_pkg::issued_instruction_t                 instruction_i;
   logic [NUM_FU_P-1:0]                                  valid_i;
   logic [NUM_FU_P-1:0]                                  fu_ready_o;
   fu_dispatch_pkg::issued_instruction_t [NUM_FU_P-1:0]  instruction_o;
   logic [NUM_FU_P-1:0]                                  valid_o;
   logic [NUM_FU_P-1:0]                                  ready_i;

   // Dispatch-controller side
   modport slave (
      input  instruction_i, valid_i, ready_i,
      output fu_ready_o, instruction_o, valid_o
   );

   // Issue-table / functional-unit side
   modport master (
      output instruction_i, valid_i, ready_i,
      input  fu_ready_o, instruction_o, valid_o
   );

endinterface

`default_nettype wire

// File: rtl/fu_dispatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fu_dispatch_ctrl                                             |
// | Description : One-entry dispatch slot per functional unit with occupancy  |
// |               tracking and a ready vector for issue-table masking.        |
// |               Optional macro FU_DISPATCH_PERF_EN adds stall counters.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module fu_dispatch_ctrl #(
   parameter int NUM_FU_P = fu_dispatch_pkg::NUM_FU,
   parameter int OCC_W_P  = 4
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   fu_dispatch_ctrl_if.slave                  bus,
   input  logic [NUM_FU_P-1:0][OCC_W_P-1:0]   occ_cfg_i,
   input  logic                               flush_i,
   output logic                               error_o
`ifdef FU_DISPATCH_PERF_EN
   ,
   output logic [NUM_FU_P-1:0][31:0]          stall_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   localparam logic [NUM_FU_P-1:0] c_vec_one = NUM_FU_P'(1);
   localparam logic [OCC_W_P-1:0]  c_cnt_one = OCC_W_P'(1);

   logic [NUM_FU_P-1:0]                                 w_fu_ready;
   logic [NUM_FU_P-1:0]                                 w_issue;
   logic [NUM_FU_P-1:0]                                 w_valid_o;
   logic [NUM_FU_P-1:0]                                 w_valid_m1;
   fu_dispatch_pkg::issued_instruction_t [NUM_FU_P-1:0] w_instr_o;
   logic                                                w_multi_hot;
   logic                                                w_not_ready;
   logic                                                w_err;
   logic                                                r_error;

   // A flushed issue is younger than the squash and is silently dropped, not an error
   assign w_valid_m1  = bus.valid_i - c_vec_one;
   assign w_multi_hot = |(bus.valid_i & w_valid_m1);
   assign w_not_ready = (|(bus.valid_i & ~w_fu_ready)) & ~flush_i;
   assign w_err       = w_multi_hot | w_not_ready;
   assign w_issue     = bus.valid_i & {NUM_FU_P{~w_err & ~flush_i}};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_error <= 1'b0;
      end else if (w_err) begin
         r_error <= 1'b1;
      end
   end

   assign error_o           = r_error;
   assign bus.fu_ready_o    = w_fu_ready;
   assign bus.valid_o       = w_valid_o;
   assign bus.instruction_o = w_instr_o;

   generate
      for (genvar g = 0; g < NUM_FU_P; g++) begin : g_fu
         state_t                               r_state;
         state_t                               w_state_nxt;
         logic [OCC_W_P-1:0]                   r_cnt;
         logic [OCC_W_P-1:0]                   w_cnt_nxt;
         fu_dispatch_pkg::issued_instruction_t r_slot;
         fu_dispatch_pkg::issued_instruction_t w_slot_nxt;
         logic                                 w_occ_zero;
         logic                                 w_cnt_last;
         logic                                 w_held;

         assign w_occ_zero = (occ_cfg_i[g] == '0);
         assign w_cnt_last = (r_cnt <= c_cnt_one);
         assign w_held     = (r_state == ST_HELD);

         assign w_fu_ready[g] = (r_state == ST_IDLE)
                              | (w_held & bus.ready_i[g] & w_occ_zero & ~flush_i)
                              | ((r_state == ST_BUSY) & w_cnt_last);

         always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_slot_nxt  = r_slot;
            case (r_state)
               ST_IDLE: begin
                  if (w_issue[g]) begin
                     w_state_nxt = ST_HELD;
                     w_slot_nxt  = bus.instruction_i;
                  end
               end
               ST_HELD: begin
                  if (flush_i) begin
                     w_state_nxt = ST_IDLE;
                     w_slot_nxt  = '0;
                  end else if (bus.ready_i[g]) begin
                     if (!w_occ_zero) begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = occ_cfg_i[g];
                        w_slot_nxt  = '0;
                     end else if (w_issue[g]) begin
                        w_slot_nxt  = bus.instruction_i;
                     end else begin
                        w_state_nxt = ST_IDLE;
                        w_slot_nxt  = '0;
                     end
                  end
               end
               ST_BUSY: begin
                  // The unit is physically occupied, so a flush does not shorten BUSY
                  w_cnt_nxt = r_cnt - c_cnt_one;
                  if (w_cnt_last) begin
                     w_cnt_nxt = '0;
                     if (w_issue[g]) begin
                        w_state_nxt = ST_HELD;
                        w_slot_nxt  = bus.instruction_i;
                     end else begin
                        w_state_nxt = ST_IDLE;
                     end
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
                  w_slot_nxt  = '0;
               end
            endcase
         end

         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_slot  <= '0;
            end else begin
               r_state <= w_state_nxt;
               r_cnt   <= w_cnt_nxt;
               r_slot  <= w_slot_nxt;
            end
         end

         assign w_valid_o[g] = w_held;
         assign w_instr_o[g] = w_held ? r_slot : '0;

`ifdef FU_DISPATCH_PERF_EN
         logic [31:0] r_stall;

         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               r_stall <= '0;
            end else if (w_held && !bus.ready_i[g] && (r_stall != 32'hFFFF_FFFF)) begin
               r_stall <= r_stall + 32'd1;
            end
         end

         assign stall_cnt_o[g] = r_stall;
`endif
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fu_dispatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fu_dispatch_ctrl                                          |
// | Description : Directed vector bench for fu_dispatch_ctrl (4 FUs, FU1 k=3). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_fu_dispatch_ctrl;

   import fu_dispatch_pkg::*;

   localparam int c_num_fu = 4;
   localparam int c_occ_w  = 4;
   localparam int c_nvec   = 24;

   logic                            clk_i;
   logic                            reset_i;
   logic [c_num_fu-1:0][c_occ_w-1:0] occ_cfg_i;
   logic                            flush_i;
   logic                            error_o;
`ifdef FU_DISPATCH_PERF_EN
   logic [c_num_fu-1:0][31:0]       stall_cnt_o;
`endif

   fu_dispatch_ctrl_if #(.NUM_FU_P(c_num_fu)) bus ();

   fu_dispatch_ctrl #(
      .NUM_FU_P (c_num_fu),
      .OCC_W_P  (c_occ_w)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .bus         (bus),
      .occ_cfg_i   (occ_cfg_i),
      .flush_i     (flush_i),
      .error_o     (error_o)
`ifdef FU_DISPATCH_PERF_EN
      ,
      .stall_cnt_o (stall_cnt_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]       vld;
      logic [15:0]      pc;
      logic [3:0]       rdy;
      logic             fl;
      logic [3:0]       frdy;
      logic [3:0]       vo;
      logic [3:0][15:0] xpc;
   } vec_t;

   vec_t vecs [c_nvec];
   int   total = 0;
   int   bad   = 0;

   function automatic issued_instruction_t mk(input logic [15:0] pc);
      issued_instruction_t r;
      r.pc     = pc;
      r.opcode = pc[7:0] ^ 8'h5A;
      r.tag    = pc[3:0] ^ 4'h3;
      return r;
   endfunction

   function automatic vec_t v(input logic [3:0] vld, input logic [15:0] pc, input logic [3:0] rdy,
                              input logic fl, input logic [3:0] frdy, input logic [3:0] vo,
                              input logic [15:0] p3, input logic [15:0] p2,
                              input logic [15:0] p1, input logic [15:0] p0);
      vec_t r;
      r.vld = vld; r.pc = pc; r.rdy = rdy; r.fl = fl; r.frdy = frdy; r.vo = vo;
      r.xpc = {p3, p2, p1, p0};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] vld, input logic [15:0] pc, input logic [3:0] rdy, input logic fl);
      @(negedge clk_i);
      bus.valid_i       = vld;
      bus.instruction_i = mk(pc);
      bus.ready_i       = rdy;
      flush_i           = fl;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_i           = 1'b1;
      bus.valid_i       = '0;
      bus.ready_i       = '0;
      bus.instruction_i = '0;
      flush_i           = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
   endtask

   task automatic chk_instr(input string nm, input logic [3:0] vo, input logic [3:0][15:0] xpc);
      for (int f = 0; f < c_num_fu; f++) begin
         chk($sformatf("%s instr%0d", nm, f), 64'(bus.instruction_o[f]),
             vo[f] ? 64'(mk(xpc[f])) : 64'd0);
      end
   endtask

   initial begin
      // FU1 occupied for 3 extra cycles after accept; others fully pipelined
      occ_cfg_i         = '0;
      occ_cfg_i[1]      = 4'd3;
      reset_i           = 1'b1;
      flush_i           = 1'b0;
      bus.valid_i       = '0;
      bus.ready_i       = '0;
      bus.instruction_i = '0;

      vecs[0]  = v(4'b0001, 16'h0040, 4'b0000, 1'b0, 4'b1111, 4'b0001, 16'h0,    16'h0,    16'h0,    16'h0040);
      vecs[1]  = v(4'b0001, 16'h0041, 4'b0001, 1'b0, 4'b1111, 4'b0001, 16'h0,    16'h0,    16'h0,    16'h0041);
      vecs[2]  = v(4'b0001, 16'h0042, 4'b0001, 1'b0, 4'b1111, 4'b0001, 16'h0,    16'h0,    16'h0,    16'h0042);
      vecs[3]  = v(4'b0000, 16'h0000, 4'b0001, 1'b0, 4'b1111, 4'b0000, 16'h0,    16'h0,    16'h0,    16'h0);
      vecs[4]  = v(4'b0010, 16'h0100, 4'b0000, 1'b0, 4'b1111, 4'b0010, 16'h0,    16'h0,    16'h0100, 16'h0);
      vecs[5]  = v(4'b0000, 16'h0000, 4'b0010, 1'b0, 4'b1101, 4'b0000, 16'h0,    16'h0,    16'h0,    16'h0);
      vecs[6]  = v(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b1101, 4'b0000, 16'h0,    16'h0,    16'h0,    16'h0);
      vecs[7]  = v(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b1101, 4'b0000, 16'h0,    16'h0,    16'h0,    16'h0);
      vecs[8]  = v(4'b0010, 16'h0101, 4'b0000, 1'b0, 4'b1111, 4'b0010, 16'h0,    16'h0,    16'h0101, 16'h0);
      vecs[9]  = v(4'b0000, 16'h0000, 4'b0010, 1'b0, 4'b1101, 4'b0000, 16'h0,    16'h0,    16'h0,    16'h0);
      vecs[10] = v(4'b0100, 16'h0200, 4'b0000, 1'b0, 4'b1101, 4'b0100, 16'h0,    16'h0200, 16'h0,    16'h0);
      vecs[11] = v(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b1001, 4'b0100, 16'h0,    16'h0200, 16'h0,    16'h0);
      vecs[12] = v(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b1011, 4'b0100, 16'h0,    16'h0200, 16'h0,    16'h0);
      vecs[13] = v(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b1011, 4'b0100, 16'h0,    16'h0200, 16'h0,    16'h0);
      vecs[14] = v(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b1011, 4'b0100, 16'h0,    16'h0200, 16'h0,    16'h0);
      vecs[15] = v(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b1011, 4'b0100, 16'h0,    16'h0200, 16'h0,    16'h0);
      vecs[16] = v(4'b0010, 16'h0102, 4'b0100, 1'b0, 4'b1111, 4'b0010, 16'h0,    16'h0,    16'h0102, 16'h0);
      vecs[17] = v(4'b0001, 16'h0050, 4'b0010, 1'b0, 4'b1101, 4'b0001, 16'h0,    16'h0,    16'h0,    16'h0050);
      vecs[18] = v(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b1100, 4'b0001, 16'h0,    16'h0,    16'h0,    16'h0050);
      vecs[19] = v(4'b0100, 16'h0300, 4'b0000, 1'b1, 4'b1100, 4'b0000, 16'h0,    16'h0,    16'h0,    16'h0);
      vecs[20] = v(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 16'h0,    16'h0,    16'h0,    16'h0);
      vecs[21] = v(4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 16'h0,    16'h0,    16'h0,    16'h0);
      vecs[22] = v(4'b1000, 16'h0A5A, 4'b1000, 1'b0, 4'b1111, 4'b1000, 16'h0A5A, 16'h0,    16'h0,    16'h0);
      vecs[23] = v(4'b0000, 16'h0000, 4'b1000, 1'b0, 4'b1111, 4'b0000, 16'h0,    16'h0,    16'h0,    16'h0);

      do_reset();
      #1;
      chk("reset valid_o",    64'(bus.valid_o),    64'h0);
      chk("reset fu_ready_o", 64'(bus.fu_ready_o), 64'hF);
      chk("reset error_o",    64'(error_o),        64'h0);
      chk_instr("reset", 4'b0000, '0);

      for (int i = 0; i < c_nvec; i++) begin
         drive(vecs[i].vld, vecs[i].pc, vecs[i].rdy, vecs[i].fl);
         #1;
         chk($sformatf("row%0d fu_ready_o", i), 64'(bus.fu_ready_o), 64'(vecs[i].frdy));
         tick();
         chk($sformatf("row%0d valid_o", i), 64'(bus.valid_o), 64'(vecs[i].vo));
         chk($sformatf("row%0d error_o", i), 64'(error_o), 64'h0);
         chk_instr($sformatf("row%0d", i), vecs[i].vo, vecs[i].xpc);
      end

`ifdef FU_DISPATCH_PERF_EN
      chk("stall_cnt fu2", 64'(stall_cnt_o[2]), 64'd5);
      chk("stall_cnt fu1", 64'(stall_cnt_o[1]), 64'd0);
`endif

      // Multi-hot issue: flagged, nothing captured, flag sticky until reset
      drive(4'b0011, 16'h0500, 4'b0000, 1'b0);
      #1;
      chk("multihot fu_ready_o", 64'(bus.fu_ready_o), 64'hF);
      tick();
      chk("multihot error_o", 64'(error_o), 64'h1);
      chk("multihot valid_o", 64'(bus.valid_o), 64'h0);
      drive(4'b0000, 16'h0000, 4'b0000, 1'b0);
      tick();
      chk("multihot error sticky", 64'(error_o), 64'h1);
      chk("multihot fsm idle", 64'(bus.fu_ready_o), 64'hF);
      do_reset();
      #1;
      chk("multihot reset clears", 64'(error_o), 64'h0);

      // Issue into a held, non-accepting slot: dropped, old instruction kept
      drive(4'b0100, 16'h0400, 4'b0000, 1'b0);
      tick();
      chk("notready first valid_o", 64'(bus.valid_o), 64'h4);
      drive(4'b0100, 16'h0401, 4'b0000, 1'b0);
      #1;
      chk("notready fu_ready_o", 64'(bus.fu_ready_o), 64'hB);
      tick();
      chk("notready error_o", 64'(error_o), 64'h1);
      chk("notready valid_o", 64'(bus.valid_o), 64'h4);
      chk("notready instr2", 64'(bus.instruction_o[2]), 64'(mk(16'h0400)));
      do_reset();
      #1;
      chk("notready reset clears", 64'(error_o), 64'h0);

      // Reset while FU0/2/3 HELD and FU1 BUSY
      drive(4'b0001, 16'h0010, 4'b0000, 1'b0); tick();
      drive(4'b0010, 16'h0011, 4'b0000, 1'b0); tick();
      drive(4'b0100, 16'h0012, 4'b0010, 1'b0); tick();
      drive(4'b1000, 16'h0013, 4'b0000, 1'b0); tick();
      chk("preload valid_o", 64'(bus.valid_o), 64'hD);
      chk("preload fu_ready_o", 64'(bus.fu_ready_o), 64'h0);
      @(negedge clk_i);
      reset_i     = 1'b1;
      bus.valid_i = '0;
      bus.ready_i = '0;
      tick();
      chk("midreset valid_o", 64'(bus.valid_o), 64'h0);
      chk("midreset fu_ready_o", 64'(bus.fu_ready_o), 64'hF);
      chk("midreset error_o", 64'(error_o), 64'h0);
      chk_instr("midreset", 4'b0000, '0);
      @(negedge clk_i);
      reset_i = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
